// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared FSM state type and default word width for the SPI deserializer
package spi_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  localparam int DEFAULT_BUS_WIDTH = 8;

endpackage

// File: rtl/spi_bit_counter.sv
// rtl/spi_bit_counter.sv - bit position counter, wraps after the last bit of a word
module spi_bit_counter #(
  parameter int bus_width = spi_pkg::DEFAULT_BUS_WIDTH
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_wrap
);

  localparam int CW = $clog2(bus_width);
  localparam logic [CW-1:0] LAST = CW'(bus_width - 1);

  logic [CW-1:0] r_count;
  logic          w_at_last;

  assign w_at_last = (r_count == LAST);
  // o_wrap marks the sample that completes a word
  assign o_wrap    = i_inc & ~i_clr & w_at_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= w_at_last ? '0 : r_count + 1'b1;
    end
  end

endmodule

// File: rtl/spi_deserializer.sv
// rtl/spi_deserializer.sv - serial-to-parallel receiver with held word, valid and overrun flags
// Build option: SPI_DESER_LSB_FIRST_EN selects LSB-first shifting (default MSB-first).
module spi_deserializer
  import spi_pkg::*;
#(
  parameter int bus_width = DEFAULT_BUS_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cs_n,
  input  logic                 enable,
  input  logic                 s_data,
  input  logic                 rd_ack,
  input  logic                 ovr_clr,
  output logic [bus_width-1:0] p_data,
  output logic                 data_valid,
  output logic                 busy,
  output logic                 overrun
);

  state_t               r_state;
  logic [bus_width-1:0] r_shreg;
  logic [bus_width-1:0] r_p_data;
  logic                 r_data_valid;
  logic                 r_overrun;

  logic                 w_sample;
  logic                 w_wrap;
  logic                 w_overrun_evt;
  logic [bus_width-1:0] w_next_shreg;

  assign w_sample = enable & ~cs_n;

`ifdef SPI_DESER_LSB_FIRST_EN
  assign w_next_shreg = {s_data, r_shreg[bus_width-1:1]};
`else
  assign w_next_shreg = {r_shreg[bus_width-2:0], s_data};
`endif

  // An ack landing on the completing edge consumes the old word, so no overrun
  assign w_overrun_evt = w_wrap & r_data_valid & ~rd_ack;

  spi_bit_counter #(
    .bus_width(bus_width)
  ) u_bit_counter (
    .clk   (clk),
    .rst   (rst),
    .i_clr (cs_n),
    .i_inc (w_sample),
    .o_wrap(w_wrap)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_shreg      <= '0;
      r_p_data     <= '0;
      r_data_valid <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      if (cs_n) begin
        r_state <= IDLE;
        r_shreg <= '0;
      end else if (w_sample) begin
        r_shreg <= w_next_shreg;
        if (w_wrap) begin
          r_state  <= IDLE;
          r_p_data <= w_next_shreg;
        end else begin
          r_state <= RECV;
        end
      end

      if (w_wrap) begin
        r_data_valid <= 1'b1;
      end else if (rd_ack) begin
        r_data_valid <= 1'b0;
      end

      if (w_overrun_evt) begin
        r_overrun <= 1'b1;
      end else if (ovr_clr) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign p_data     = r_p_data;
  assign data_valid = r_data_valid;
  assign overrun    = r_overrun;
  assign busy       = (r_state == RECV);

endmodule
